mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the execute stage and the 256×16 data memory. Accepts one load or store request at a time over a valid/ready handshake and drives the memory's read enable, write enable, address and write-data for exactly one cycle. For loads, it captures the memory's registered read data and returns it, tagged with the destination register, over a second valid/ready handshake to writeback. Out-of-range or malformed requests are rejected without touching memory.

## Interface
- DATA_W, 16, data and address width
- MEM_AW, 8, implemented memory address bits; addr[DATA_W-1:MEM_AW] must be zero
- REG_W, 3, destination register tag width

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_is_load  in  1  request is a load
- req_is_store  in  1  request is a store
- req_addr  in  DATA_W  word address
- req_wdata  in  DATA_W  store data
- req_rd  in  REG_W  load destination tag
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  DATA_W  to memory address
- mem_wdata  out  DATA_W  to memory write_data
- mem_rdata  in  DATA_W  from memory read_data; registered in memory, valid the cycle after mem_read
- resp_valid  out  1  load/error response present
- resp_ready  in  1  writeback accepts response
- resp_data  out  DATA_W  load data; 0 on error
- resp_rd  out  REG_W  echoed req_rd
- resp_err  out  1  request was rejected
- load_count  out  16  completed loads, wraps 0xFFFF→0
- store_count  out  16  completed stores, wraps 0xFFFF→0

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE
  - req_ready=1.
  - When req_valid is high at the clock edge, latch addr, wdata, rd, is_load and is_store.
  - Error if is_load==is_store (neither or both set) or addr[15:8]!=0. On error, go to RESP with resp_err=1 and resp_data=0.
  - Otherwise go to ISSUE.
- ISSUE
  - mem_addr=latched addr.
  - Load: mem_read=1. Next state is WAIT.
  - Store: mem_write=1 and mem_wdata=latched wdata. store_count increments at the end of the cycle. Next state is IDLE. Stores produce no response.
- WAIT
  - mem_read=0 and mem_write=0.
  - At the edge, sample mem_rdata into resp_data. Next state is RESP.
- RESP
  - resp_valid=1. resp_data, resp_rd and resp_err are held stable until resp_ready is high at an edge.
  - On that handshake, return to IDLE. load_count increments only for non-error responses.
- In every state other than ISSUE, mem_read=0 and mem_write=0.
- mem_addr and mem_wdata hold their last value when not in ISSUE.
- req_ready is 0 in ISSUE, WAIT and RESP. Requests presented in those states are ignored and are not latched.
- No overlap: at most one request in flight.

## Timing
- Reset (rst_n low) takes effect immediately, without waiting for clk:
  - state is IDLE;
  - req_ready=0 while rst_n is low, then 1 from the first cycle after release;
  - mem_read, mem_write, resp_valid and resp_err are 0;
  - mem_addr, mem_wdata, resp_data, resp_rd, load_count and store_count are 0.
- Reset mid-operation:
  - A store in ISSUE is abandoned; mem_write drops immediately.
  - A pending response is discarded.
  - Counters are cleared.
- Load, request accepted at edge E:
  - ISSUE during cycle E..E+1;
  - memory captures at E+1;
  - WAIT during E+1..E+2;
  - resp_valid rises after E+2;
  - earliest return to IDLE at E+3 (resp_ready already high).
  - Throughput: one load per 4 cycles.
- Store, request accepted at edge E: mem_write is high for exactly the cycle E..E+1, and req_ready is high again after E+1. Throughput: one store per 2 cycles.
- Error, request accepted at E: resp_valid rises after E, with no memory enable at any point.
- resp_ready held low: the unit stays in RESP indefinitely with outputs stable. req_ready stays 0.
- Counters increment by exactly 1 per completion and wrap modulo 2^16.

## Test plan
- Reset, then store addr=0x0005 data=0xAAAA -> mem_write high one cycle with mem_addr=0x0005 and mem_wdata=0xAAAA; store_count=1; no resp_valid.
- Then load addr=0x0005 rd=3 -> mem_read high one cycle; resp_valid 3 cycles after accept with resp_data=0xAAAA, resp_rd=3, resp_err=0; load_count=1.
- Load with resp_ready low for 5 cycles -> resp_valid and resp_data stable for all 5 cycles; req_ready=0 throughout, and a request presented meanwhile is not accepted; completes on resp_ready.
- Load addr=0x0100, then a request with both is_load and is_store set -> each gives resp_err=1 and resp_data=0, no mem_read or mem_write, counters unchanged.
- Assert rst_n low during the ISSUE cycle of a store to 0x00FF -> mem_write drops immediately; after release, a load of 0x00FF returns the prior contents; counters are 0 until new completions.
- Force store_count=0xFFFF via 65535 stores plus one more -> store_count wraps to 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and a 256x16 data memory.
// One request in flight; loads and rejected requests answer over a response handshake.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned REG_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_load_i,
  input  logic              req_is_store_i,
  input  logic [DATA_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [REG_W-1:0]  req_rd_i,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [REG_W-1:0]  resp_rd_o,
  output logic              resp_err_o,
  output logic [15:0]       load_count_o,
  output logic [15:0]       store_count_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q;
  logic                mem_read_q, mem_write_q;
  logic [DATA_W-1:0]   mem_addr_q, mem_wdata_q;
  logic                resp_valid_q, resp_err_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [REG_W-1:0]    resp_rd_q;
  logic [15:0]         load_count_q, store_count_q;
  logic                req_err;

  assign req_err = (req_is_load_i == req_is_store_i) || (|req_addr_i[DATA_W-1:MEM_AW]);

  // In ISSUE the enable that is set doubles as the latched request kind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
      resp_rd_q     <= '0;
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (req_err) begin
              resp_rd_q    <= req_rd_i;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              mem_addr_q <= req_addr_i;
              if (req_is_load_i) begin
                mem_read_q <= 1'b1;
                resp_rd_q  <= req_rd_i;
                resp_err_q <= 1'b0;
              end else begin
                mem_write_q <= 1'b1;
                mem_wdata_q <= req_wdata_i;
              end
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (mem_write_q) begin
            store_count_q <= store_count_q + 16'd1;
            state_q       <= StIdle;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          resp_data_q  <= mem_rdata_i;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            if (!resp_err_q) load_count_q <= load_count_q + 16'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by rst_ni so the unit never looks ready while held in reset.
  assign req_ready_o   = rst_ni && (state_q == StIdle);
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_data_o   = resp_data_q;
  assign resp_rd_o     = resp_rd_q;
  assign resp_err_o    = resp_err_q;
  assign load_count_o  = load_count_q;
  assign store_count_o = store_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 256x16 registered memory, transaction-level reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic        req_is_load_i = 1'b0, req_is_store_i = 1'b0;
  logic [15:0] req_addr_i = '0, req_wdata_i = '0;
  logic [2:0]  req_rd_i = '0;
  logic        mem_read_o, mem_write_o;
  logic [15:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        resp_valid_o, resp_ready_i = 1'b1, resp_err_o;
  logic [15:0] resp_data_o;
  logic [2:0]  resp_rd_o;
  logic [15:0] load_count_o, store_count_o;

  mem_access_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_is_load_i (req_is_load_i),
    .req_is_store_i(req_is_store_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_rd_i      (req_rd_i),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_data_o   (resp_data_o),
    .resp_rd_o     (resp_rd_o),
    .resp_err_o    (resp_err_o),
    .load_count_o  (load_count_o),
    .store_count_o (store_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Physical memory seen by the DUT: registered read, synchronous write.
  logic [15:0] phys_mem [256];
  always @(posedge clk_i) begin
    if (mem_write_o) phys_mem[mem_addr_o[7:0]] <= mem_wdata_o;
    if (mem_read_o)  mem_rdata_i <= phys_mem[mem_addr_o[7:0]];
  end

  // Reference model: one transaction, tracked by its kind and the edges since acceptance.
  typedef enum int {KLoad, KStore, KErr} kind_e;
  logic [15:0] ref_mem [256];
  bit          m_busy = 1'b0;
  kind_e       m_kind = KLoad;
  int          m_age = 0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_data = '0, m_lc = '0, m_sc = '0;
  logic [2:0]  m_rd = '0;
  logic        m_err = 1'b0;

  function automatic bit resp_shown();
    return m_busy && (m_kind == KErr || (m_kind == KLoad && m_age >= 2));
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 1'b0; m_age = 0; m_addr = '0; m_wdata = '0; m_data = '0;
      m_lc = '0; m_sc = '0; m_rd = '0; m_err = 1'b0;
    end else if (m_busy) begin
      if (resp_shown()) begin
        if (resp_ready_i) begin
          if (m_kind == KLoad) m_lc = m_lc + 16'd1;
          m_busy = 1'b0;
        end
      end else if (m_kind == KStore) begin
        ref_mem[m_addr[7:0]] = m_wdata;
        m_sc = m_sc + 16'd1;
        m_busy = 1'b0;
      end else if (m_age == 1) begin
        m_data = ref_mem[m_addr[7:0]];
      end
      m_age++;
    end else if (req_valid_i) begin
      m_busy = 1'b1;
      m_age  = 0;
      if (req_is_load_i == req_is_store_i || req_addr_i > 16'h00FF) begin
        m_kind = KErr; m_rd = req_rd_i; m_data = '0; m_err = 1'b1;
      end else begin
        m_addr = req_addr_i;
        if (req_is_load_i) begin
          m_kind = KLoad; m_rd = req_rd_i; m_err = 1'b0;
        end else begin
          m_kind = KStore; m_wdata = req_wdata_i;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (checking) begin
      chk("req_ready", req_ready_o, rst_ni && !m_busy);
      chk("mem_read", mem_read_o, m_busy && m_kind == KLoad && m_age == 0);
      chk("mem_write", mem_write_o, m_busy && m_kind == KStore && m_age == 0);
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_wdata", mem_wdata_o, m_wdata);
      chk("resp_valid", resp_valid_o, resp_shown());
      chk("load_count", load_count_o, m_lc);
      chk("store_count", store_count_o, m_sc);
      if (resp_shown()) begin
        chk("resp_data", resp_data_o, m_data);
        chk("resp_rd", resp_rd_o, m_rd);
        chk("resp_err", resp_err_o, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input bit ld, input bit st, input logic [15:0] a,
                       input logic [15:0] wd, input logic [2:0] rd);
    req_valid_i = v; req_is_load_i = ld; req_is_store_i = st;
    req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] wd);
    drive(1, 0, 1, a, wd, 0);
    tick();
    chk("st_mem_write", mem_write_o, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      phys_mem[i] = {b, b} ^ 16'h5A5A;
      ref_mem[i]  = {b, b} ^ 16'h5A5A;
    end
    #1 rst_ni = 1'b0;
    checking = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_store_count", store_count_o, 0);
    rst_ni = 1'b1;
    #1 chk("rel_req_ready", req_ready_o, 1);
    tick();

    // Store 0x0005 <- 0xAAAA
    drive(1, 0, 1, 16'h0005, 16'hAAAA, 0);
    tick();
    chk("st5_write", mem_write_o, 1);
    chk("st5_addr", mem_addr_o, 16'h0005);
    chk("st5_wdata", mem_wdata_o, 16'hAAAA);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("st5_count", store_count_o, 1);
    chk("st5_noresp", resp_valid_o, 0);
    chk("st5_ready", req_ready_o, 1);

    // Load 0x0005 into r3
    drive(1, 1, 0, 16'h0005, 0, 3'd3);
    tick();
    chk("ld5_read", mem_read_o, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("ld5_wait_valid", resp_valid_o, 0);
    tick();
    chk("ld5_valid", resp_valid_o, 1);
    chk("ld5_data", resp_data_o, 16'hAAAA);
    chk("ld5_rd", resp_rd_o, 3);
    chk("ld5_err", resp_err_o, 0);
    tick();
    chk("ld5_count", load_count_o, 1);

    // Load with writeback stalled; a store presented meanwhile must be ignored
    resp_ready_i = 1'b0;
    drive(1, 1, 0, 16'h0005, 0, 3'd6);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(1, 0, 1, 16'h0009, 16'hBEEF, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", resp_valid_o, 1);
      chk("stall_data", resp_data_o, 16'hAAAA);
      chk("stall_ready", req_ready_o, 0);
      tick();
    end
    resp_ready_i = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("stall_done", resp_valid_o, 0);
    chk("stall_lcount", load_count_o, 2);
    chk("stall_scount", store_count_o, 1);

    // Rejected requests: high address, then both kinds set
    drive(1, 1, 0, 16'h0100, 0, 3'd2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("err_hi_valid", resp_valid_o, 1);
    chk("err_hi_err", resp_err_o, 1);
    chk("err_hi_data", resp_data_o, 0);
    chk("err_hi_read", mem_read_o, 0);
    tick();
    drive(1, 1, 1, 16'h0007, 16'h1111, 3'd4);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("err_both_err", resp_err_o, 1);
    chk("err_both_data", resp_data_o, 0);
    chk("err_both_write", mem_write_o, 0);
    tick();
    chk("err_lcount", load_count_o, 2);
    chk("err_scount", store_count_o, 1);

    // Reset during the ISSUE cycle of a store to 0x00FF
    drive(1, 0, 1, 16'h00FF, 16'h1234, 0);
    tick();
    chk("rst_st_write_hi", mem_write_o, 1);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_st_write_lo", mem_write_o, 0);
    chk("rst_st_scount", store_count_o, 0);
    chk("rst_st_lcount", load_count_o, 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
    drive(1, 1, 0, 16'h00FF, 0, 3'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("ff_data", resp_data_o, 16'hA5A5);
    tick();
    chk("ff_lcount", load_count_o, 1);

    // Randomized traffic with random writeback back-pressure
    for (int c = 0; c < 4000; c++) begin
      int r;
      logic [15:0] a;
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      drive($urandom_range(0, 2) != 0, (r < 4) || (r == 8), (r >= 4 && r < 9), a,
            16'($urandom), 3'($urandom));
      resp_ready_i = $urandom_range(0, 3) != 0;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    resp_ready_i = 1'b1;
    for (int i = 0; i < 10 && !req_ready_o; i++) tick();
    chk("drain_ready", req_ready_o, 1);

    // Counter wrap: start store_count just below the top
    dut.store_count_q = 16'hFFFE;
    m_sc = 16'hFFFE;
    do_store(16'h0010, 16'h0F0F);
    chk("wrap_ffff", store_count_o, 16'hFFFF);
    do_store(16'h0011, 16'hF0F0);
    chk("wrap_zero", store_count_o, 16'h0000);
    tick();

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
